// File: rtl/pc_next_unit_pkg.sv
// Shared types and constants for the RV32I program-counter / next-PC block.
package pc_next_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } pc_state_t;

    typedef enum logic [1:0] {
        TGT_SEQ    = 2'd0,
        TGT_BRANCH = 2'd1,
        TGT_JAL    = 2'd2,
        TGT_JALR   = 2'd3
    } target_kind_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    localparam logic [31:0] INSTR_BYTES          = 32'd4;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Without the C extension every fetch target must be word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    function automatic target_kind_t kind_from_opcode(input logic [6:0] opcode);
        target_kind_t kind;
        case (opcode)
            OPC_BRANCH: kind = TGT_BRANCH;
            OPC_JAL:    kind = TGT_JAL;
            OPC_JALR:   kind = TGT_JALR;
            default:    kind = TGT_SEQ;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/pc_next_unit_target_sel.sv
// Combinational next-PC target mux with priority jalr > jal > taken branch > sequential,
// plus the alignment check on redirected targets.
module pc_target_sel
    import pc_next_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        branch,
    output logic [31:0] seq_target,
    output logic [31:0] target,
    output logic        redirect,
    output logic        misaligned
);

    target_kind_t kind;
    logic [31:0]  rel_target;
    logic [31:0]  jalr_sum;

    assign seq_target = pc + INSTR_BYTES;
    assign rel_target = pc + imm;
    assign jalr_sum   = rs1_data + imm;

    always_comb begin
        kind = TGT_SEQ;
        if (is_jalr) begin
            kind = TGT_JALR;
        end else if (is_jal) begin
            kind = TGT_JAL;
        end else if (is_branch && branch) begin
            kind = TGT_BRANCH;
        end
    end

    always_comb begin
        target = seq_target;
        case (kind)
            TGT_JALR:   target = jalr_sum & ~32'h0000_0001;
            TGT_JAL:    target = rel_target;
            TGT_BRANCH: target = rel_target;
            default:    target = seq_target;
        endcase
    end

    // The sequential path is always aligned, so only redirects can trap.
    assign redirect   = (kind != TGT_SEQ);
    assign misaligned = redirect && is_misaligned(target);

endmodule

// File: rtl/pc_next_unit.sv
// PC register, boot/run/trap sequencing and branch statistics for the single-cycle RV32I core.
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_ready,
    input  logic             stall,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic             branch,
    input  logic [31:0]      imm,
    input  logic [31:0]      rs1_data,
    input  logic             trap_ack,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             pc_valid,
    output logic             misalign_trap,
    output logic [31:0]      trap_pc,
    output logic [31:0]      trap_tval,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] br_taken_count
);

    pc_state_t   state;
    logic [31:0] target;
    logic        redirect;
    logic        misaligned;
    logic        advance;
    logic        retire;

    pc_target_sel u_target_sel (
        .pc         (pc),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .is_branch  (is_branch),
        .is_jal     (is_jal),
        .is_jalr    (is_jalr),
        .branch     (branch),
        .seq_target (pc_plus4),
        .target     (target),
        .redirect   (redirect),
        .misaligned (misaligned)
    );

    assign advance = (state == ST_RUN) && !stall && imem_ready;
    assign retire  = advance && !misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_BOOT;
            pc            <= RESET_VECTOR;
            pc_valid      <= 1'b0;
            misalign_trap <= 1'b0;
            trap_pc       <= 32'h0;
            trap_tval     <= 32'h0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state    <= ST_RUN;
                    pc_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (advance) begin
                        if (misaligned) begin
                            state         <= ST_TRAP;
                            pc_valid      <= 1'b0;
                            misalign_trap <= 1'b1;
                            trap_pc       <= pc;
                            trap_tval     <= target;
                        end else begin
                            pc <= target;
                        end
                    end
                end
                ST_TRAP: begin
                    if (trap_ack) begin
                        state         <= ST_RUN;
                        pc            <= TRAP_VECTOR;
                        pc_valid      <= 1'b1;
                        misalign_trap <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_BOOT;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

    // A trapping instruction never retires, so it is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count       <= '0;
            br_taken_count <= '0;
        end else if (retire && is_branch) begin
            br_count <= br_count + CNT_W'(1);
            if (branch) begin
                br_taken_count <= br_taken_count + CNT_W'(1);
            end
        end
    end

    logic unused_redirect;
    assign unused_redirect = redirect;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: a reference model predicts each cycle's outputs,
// which are queued on drive and compared after the clock edge.
module tb_pc_next_unit;

    localparam int          CNT_W = 8;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] TV    = 32'h0000_0100;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             imem_ready = 1'b1;
    logic             stall = 1'b0;
    logic             is_branch = 1'b0;
    logic             is_jal = 1'b0;
    logic             is_jalr = 1'b0;
    logic             branch = 1'b0;
    logic [31:0]      imm = 32'h0;
    logic [31:0]      rs1_data = 32'h0;
    logic             trap_ack = 1'b0;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             pc_valid;
    logic             misalign_trap;
    logic [31:0]      trap_pc;
    logic [31:0]      trap_tval;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] br_taken_count;

    pc_next_unit #(
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_ready     (imem_ready),
        .stall          (stall),
        .is_branch      (is_branch),
        .is_jal         (is_jal),
        .is_jalr        (is_jalr),
        .branch         (branch),
        .imm            (imm),
        .rs1_data       (rs1_data),
        .trap_ack       (trap_ack),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .pc_valid       (pc_valid),
        .misalign_trap  (misalign_trap),
        .trap_pc        (trap_pc),
        .trap_tval      (trap_tval),
        .br_count       (br_count),
        .br_taken_count (br_taken_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic [31:0]      pc;
        logic             valid;
        logic             trap;
        logic [31:0]      tpc;
        logic [31:0]      tval;
        logic [CNT_W-1:0] bc;
        logic [CNT_W-1:0] btc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: 0 = boot, 1 = run, 2 = trap.
    int               m_state = 0;
    logic [31:0]      m_pc = RV;
    logic             m_valid = 1'b0;
    logic             m_trap = 1'b0;
    logic [31:0]      m_tpc = 32'h0;
    logic [31:0]      m_tval = 32'h0;
    logic [CNT_W-1:0] m_bc = '0;
    logic [CNT_W-1:0] m_btc = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_state = 0;
        m_pc    = RV;
        m_valid = 1'b0;
        m_trap  = 1'b0;
        m_tpc   = 32'h0;
        m_tval  = 32'h0;
        m_bc    = '0;
        m_btc   = '0;
    endtask

    // Drives one cycle of inputs, predicts the result, then checks it after the edge.
    task automatic applyStimulus(input string tag, input logic br_i, input logic taken_i,
                                 input logic jal_i, input logic jalr_i, input logic [31:0] imm_i,
                                 input logic [31:0] rs1_i, input logic stall_i, input logic rdy_i,
                                 input logic ack_i);
        logic [31:0] tgt;
        logic        redir;
        exp_t        e;
        is_branch  = br_i;
        branch     = taken_i;
        is_jal     = jal_i;
        is_jalr    = jalr_i;
        imm        = imm_i;
        rs1_data   = rs1_i;
        stall      = stall_i;
        imem_ready = rdy_i;
        trap_ack   = ack_i;
        case (m_state)
            0: begin
                m_state = 1;
                m_valid = 1'b1;
            end
            1: begin
                if (!stall_i && rdy_i) begin
                    tgt   = m_pc + 32'd4;
                    redir = 1'b0;
                    if (jalr_i) begin
                        tgt   = (rs1_i + imm_i) & 32'hFFFF_FFFE;
                        redir = 1'b1;
                    end else if (jal_i || (br_i && taken_i)) begin
                        tgt   = m_pc + imm_i;
                        redir = 1'b1;
                    end
                    if (redir && tgt[1:0] != 2'b00) begin
                        m_tpc   = m_pc;
                        m_tval  = tgt;
                        m_trap  = 1'b1;
                        m_valid = 1'b0;
                        m_state = 2;
                    end else begin
                        m_pc = tgt;
                        if (br_i) m_bc++;
                        if (br_i && taken_i) m_btc++;
                    end
                end
            end
            default: begin
                if (ack_i) begin
                    m_pc    = TV;
                    m_trap  = 1'b0;
                    m_valid = 1'b1;
                    m_state = 1;
                end
            end
        endcase
        e.tag = tag; e.pc = m_pc; e.valid = m_valid; e.trap = m_trap;
        e.tpc = m_tpc; e.tval = m_tval; e.bc = m_bc; e.btc = m_btc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput({e.tag, ".pc"}, pc, e.pc);
        checkOutput({e.tag, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
        checkOutput({e.tag, ".valid"}, 32'(pc_valid), 32'(e.valid));
        checkOutput({e.tag, ".trap"}, 32'(misalign_trap), 32'(e.trap));
        checkOutput({e.tag, ".trap_pc"}, trap_pc, e.tpc);
        checkOutput({e.tag, ".trap_tval"}, trap_tval, e.tval);
        checkOutput({e.tag, ".br_count"}, 32'(br_count), 32'(e.bc));
        checkOutput({e.tag, ".br_taken"}, 32'(br_taken_count), 32'(e.btc));
        @(negedge clk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".pc"}, pc, RV);
        checkOutput({tag, ".valid"}, 32'(pc_valid), 32'h0);
        checkOutput({tag, ".trap"}, 32'(misalign_trap), 32'h0);
        checkOutput({tag, ".trap_pc"}, trap_pc, 32'h0);
        checkOutput({tag, ".trap_tval"}, trap_tval, 32'h0);
        checkOutput({tag, ".br_count"}, 32'(br_count), 32'h0);
        checkOutput({tag, ".br_taken"}, 32'(br_taken_count), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        checkResetState("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Boot then straight-line fetch.
        applyStimulus("boot", 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
        checkOutput("boot_valid", 32'(pc_valid), 32'h1);
        checkOutput("boot_pc", pc, 32'h0);
        applyStimulus("seq1", 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
        applyStimulus("seq2", 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
        checkOutput("seq_pc8", pc, 32'h8);

        // Branch taken / not taken from 0x40.
        applyStimulus("jal40", 0, 0, 1, 0, 32'h38, 32'h0, 0, 1, 0);
        applyStimulus("br_tk", 1, 1, 0, 0, 32'hFFFF_FFF8, 32'h0, 0, 1, 0);
        checkOutput("br_tk_pc", pc, 32'h38);
        checkOutput("br_tk_cnt", 32'(br_count), 32'h1);
        checkOutput("br_tk_taken", 32'(br_taken_count), 32'h1);
        applyStimulus("jal40b", 0, 0, 1, 0, 32'h8, 32'h0, 0, 1, 0);
        applyStimulus("br_nt", 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, 0, 1, 0);
        checkOutput("br_nt_pc", pc, 32'h44);
        checkOutput("br_nt_cnt", 32'(br_count), 32'h2);
        checkOutput("br_nt_taken", 32'(br_taken_count), 32'h1);

        // Misaligned JALR target traps until acknowledged.
        applyStimulus("jal10", 0, 0, 1, 0, 32'hFFFF_FFCC, 32'h0, 0, 1, 0);
        applyStimulus("jalr_mis", 0, 0, 0, 1, 32'h0, 32'h203, 0, 1, 0);
        checkOutput("mis_trap", 32'(misalign_trap), 32'h1);
        checkOutput("mis_tpc", trap_pc, 32'h10);
        checkOutput("mis_tval", trap_tval, 32'h202);
        checkOutput("mis_pc", pc, 32'h10);
        checkOutput("mis_valid", 32'(pc_valid), 32'h0);
        applyStimulus("trap_hold1", 1, 1, 1, 0, 32'h40, 32'h0, 0, 1, 0);
        applyStimulus("trap_hold2", 0, 0, 0, 1, 32'h8, 32'h10, 0, 1, 0);
        applyStimulus("trap_ack", 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 1);
        checkOutput("ack_pc", pc, 32'h100);
        checkOutput("ack_valid", 32'(pc_valid), 32'h1);
        checkOutput("ack_trap", 32'(misalign_trap), 32'h0);
        applyStimulus("ack_in_run", 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 1);

        // Stall and fetch back-pressure hold everything.
        applyStimulus("stall1", 0, 0, 1, 0, 32'h20, 32'h0, 1, 1, 0);
        applyStimulus("stall2", 1, 1, 1, 0, 32'h20, 32'h0, 0, 0, 0);
        applyStimulus("stall3", 1, 1, 1, 0, 32'h20, 32'h0, 1, 0, 0);
        applyStimulus("release", 0, 0, 1, 0, 32'h20, 32'h0, 0, 1, 0);
        checkOutput("release_pc", pc, 32'h124);

        // Priority and alignment boundaries.
        applyStimulus("prio_jalr", 0, 0, 1, 1, 32'h5, 32'h300, 0, 1, 0);
        checkOutput("prio_pc", pc, 32'h304);
        applyStimulus("jalr_lsb", 0, 0, 0, 1, 32'h0, 32'h401, 0, 1, 0);
        checkOutput("jalr_lsb_pc", pc, 32'h400);
        applyStimulus("nt_oddimm", 1, 0, 0, 0, 32'h2, 32'h0, 0, 1, 0);
        checkOutput("nt_oddimm_pc", pc, 32'h404);
        applyStimulus("br_mis", 1, 1, 0, 0, 32'h6, 32'h0, 0, 1, 0);
        checkOutput("br_mis_cnt", 32'(br_count), 32'h3);
        checkOutput("br_mis_tval", trap_tval, 32'h40A);
        applyStimulus("br_mis_ack", 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 1);

        // PC wraps at 2^32.
        applyStimulus("jal_top", 0, 0, 1, 0, 32'hFFFF_FEFC, 32'h0, 0, 1, 0);
        checkOutput("top_pc", pc, 32'hFFFF_FFFC);
        checkOutput("top_plus4", pc_plus4, 32'h0);
        applyStimulus("wrap_seq", 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
        checkOutput("wrap_pc", pc, 32'h0);

        // Branch counters wrap at 2^CNT_W.
        for (int i = 0; i < 300 && m_bc != {CNT_W{1'b1}}; i++) begin
            applyStimulus("cnt_fill", 1, 1'(i % 2), 0, 0, 32'h4, 32'h0, 0, 1, 0);
        end
        checkOutput("cnt_full", 32'(br_count), 32'(2 ** CNT_W - 1));
        applyStimulus("cnt_wrap", 1, 1, 0, 0, 32'h4, 32'h0, 0, 1, 0);
        checkOutput("cnt_wrap_val", 32'(br_count), 32'h0);

        // Asynchronous reset asserted mid-trap, between clock edges.
        applyStimulus("pre_rst_trap", 0, 0, 1, 0, 32'h2, 32'h0, 0, 1, 0);
        checkOutput("pre_rst_trap_on", 32'(misalign_trap), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("async_rst");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("reboot", 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
        applyStimulus("reboot_seq", 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
        checkOutput("reboot_pc", pc, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
